// File: rtl/zx_matrix_keyboard.sv
// ZX Spectrum keyboard matrix emulator.
// The HID MCU loads key switch commands over a 3-wire serial link (DAT/SK/STB).
// The module holds a ROWS x COLS key matrix plus the MAGIC, RESET and PAUSE keys.
// It answers Z80 reads of port #FE with the half-rows selected by A8..A15.
// The RESET output is stretched to at least RST_MIN cycles.
// Optional macro KBD_WATCHDOG_EN builds a link-silence watchdog. When the link
// has been quiet for WDT_CYCLES cycles, the watchdog releases every key.
module zx_matrix_keyboard #(
   parameter int ROWS       = 8,
   parameter int COLS       = 5,
   parameter int RST_MIN    = 1024,
   parameter int WDT_CYCLES = 1048576
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        DAT,
   input  logic        SK,
   input  logic        STB,
   input  logic [15:0] A,
   input  logic        M1,
   input  logic        RD,
   input  logic        IORQ,
   output logic [7:0]  D,
   output logic        enable,
   output logic        IORQGE,
   output logic        PAUSE,
   output logic        MAGIC,
   output logic        RESET
);

   localparam int RCW = (RST_MIN > 1) ? $clog2(RST_MIN) : 1;

   // Synchroniser chains; bit 0 = DAT, bit 1 = SK, bit 2 = STB
   logic [2:0] sync1_q, sync2_q, hist_q;
   logic       sk_edge, stb_edge;

   // Edge events registered together with the DAT sample taken in the same cycle
   logic       sk_ev_q, stb_ev_q, dat_ev_q;

   logic [6:0]      addr_q, addr_d;
   logic [COLS-1:0] key_q [ROWS];
   logic [COLS-1:0] key_d [ROWS];
   logic            magic_q, magic_d;
   logic            pause_q, pause_d;
   logic            rkey_q, rkey_d;
   logic            reset_q, reset_d;
   logic [RCW-1:0]  cnt_q, cnt_d;

`ifdef KBD_WATCHDOG_EN
   localparam int WW = $clog2(WDT_CYCLES + 1);
   logic [WW-1:0] wdt_q, wdt_d;
`endif

   assign sk_edge  = sync2_q[1] & ~hist_q[1];
   assign stb_edge = sync2_q[2] & ~hist_q[2];

   // Three-stage synchroniser plus one event stage, so a pin rise lands at edge n+3
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         hist_q   <= '0;
         sk_ev_q  <= 1'b0;
         stb_ev_q <= 1'b0;
         dat_ev_q <= 1'b0;
      end else begin
         sync1_q  <= {STB, SK, DAT};
         sync2_q  <= sync1_q;
         hist_q   <= sync2_q;
         sk_ev_q  <= sk_edge;
         stb_ev_q <= stb_edge;
         dat_ev_q <= sync2_q[0];
      end
   end

   // Next-state logic: address shift, command decode, watchdog release, RESET stretch
   always_comb begin
      addr_d  = addr_q;
      key_d   = key_q;
      magic_d = magic_q;
      pause_d = pause_q;
      rkey_d  = rkey_q;
      cnt_d   = cnt_q;
`ifdef KBD_WATCHDOG_EN
      wdt_d   = wdt_q;
`endif

      if (sk_ev_q) begin
         addr_d = {addr_q[5:0], dat_ev_q};
      end

`ifdef KBD_WATCHDOG_EN
      if (stb_ev_q) begin
         wdt_d = '0;
      end else if (wdt_q < WW'(WDT_CYCLES)) begin
         wdt_d = wdt_q + 1'b1;
         // The counter stops one above the trip value, so the release fires once
         if (wdt_q == WW'(WDT_CYCLES - 1)) begin
            for (int r = 0; r < ROWS; r++) begin
               key_d[r] = '1;
            end
            magic_d = 1'b0;
            pause_d = 1'b0;
            rkey_d  = 1'b0;
         end
      end
`endif

      // Decode uses addr_q, which is the address before any shift in this same cycle
      if (stb_ev_q) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               if (addr_q[3:0] == 4'(r) && addr_q[6:4] == 3'(c)) begin
                  key_d[r][c] = ~dat_ev_q;
               end
            end
         end
         if (addr_q[3:0] == 4'd8) begin
            case (addr_q[6:4])
               3'd5:    magic_d = dat_ev_q;
               3'd6:    rkey_d  = dat_ev_q;
               3'd7:    pause_d = dat_ev_q;
               default: ;
            endcase
         end
      end

      // A press loads the counter (or reloads it on a re-press). Otherwise the
      // counter runs down to zero.
      if (rkey_d && !rkey_q) begin
         cnt_d = RCW'(RST_MIN - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end

      // The old counter value is used here, so RESET lasts exactly RST_MIN cycles
      reset_d = rkey_d | (cnt_q != '0);
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         magic_q <= 1'b0;
         pause_q <= 1'b0;
         rkey_q  <= 1'b0;
         reset_q <= 1'b0;
         cnt_q   <= '0;
         for (int r = 0; r < ROWS; r++) begin
            key_q[r] <= '1;
         end
      end else begin
         addr_q  <= addr_d;
         magic_q <= magic_d;
         pause_q <= pause_d;
         rkey_q  <= rkey_d;
         reset_q <= reset_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
      end
   end

`ifdef KBD_WATCHDOG_EN
   // Link-silence counter
   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_q <= '0;
      end else begin
         wdt_q <= wdt_d;
      end
   end
`endif

   // Half-row masking: a row contributes only when its address line is low
   logic [COLS-1:0] row_sel [ROWS];
   logic [COLS-1:0] keys;

   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      assign row_sel[gi] = key_q[gi] | {COLS{A[8+gi]}};
   end

   // AND all selected rows together; a pressed key anywhere pulls its bit low
   always_comb begin
      keys = '1;
      for (int r = 0; r < ROWS; r++) begin
         keys = keys & row_sel[r];
      end
   end

   assign D      = {{(8 - COLS){1'b1}}, keys};
   assign IORQGE = A[0] | RD | ~M1;
   assign enable = ~(IORQGE | IORQ);
   assign MAGIC  = magic_q;
   assign PAUSE  = pause_q;
   assign RESET  = reset_q;

   logic unused_bits;
   assign unused_bits = ^{A[7:1], hist_q[0]};

endmodule

// File: tb/tb_zx_matrix_keyboard.sv
// Directed bench for zx_matrix_keyboard (ROWS=8, COLS=5, RST_MIN=100, WDT_CYCLES=64).
module tb_zx_matrix_keyboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        DAT, SK, STB;
   logic [15:0] A;
   logic        M1, RD, IORQ;
   logic [7:0]  D;
   logic        enable, IORQGE, PAUSE, MAGIC, RESET;

   int total = 0;
   int bad   = 0;
   int rst_hi = 0;
   bit mon_en = 1'b0;

   zx_matrix_keyboard #(
      .ROWS(8), .COLS(5), .RST_MIN(100), .WDT_CYCLES(64)
   ) dut (
      .clk(clk), .rst(rst), .DAT(DAT), .SK(SK), .STB(STB),
      .A(A), .M1(M1), .RD(RD), .IORQ(IORQ),
      .D(D), .enable(enable), .IORQGE(IORQGE),
      .PAUSE(PAUSE), .MAGIC(MAGIC), .RESET(RESET)
   );

   always #5 clk = ~clk;

   // Count the cycles in which RESET is high
   always @(posedge clk) begin
      #1;
      if (mon_en && RESET) rst_hi++;
   end

   typedef struct {
      logic [15:0] a;
      logic        m1, rd, iorq;
      logic [7:0]  d;
      logic        en, ge;
      string       name;
   } vec_t;

   vec_t vec [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("check %s ok (%h)", name, act);
      end
   endtask

   task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp_d);
      A = a; M1 = 1'b1; RD = 1'b0; IORQ = 1'b0;
      #1;
      chk(name, {24'h0, D}, {24'h0, exp_d});
   endtask

   task automatic send_bit(input logic b);
      DAT = b;
      tick();
      SK = 1'b1;
      tick(); tick();
      SK = 1'b0;
      tick(); tick();
   endtask

   task automatic send_addr(input logic [2:0] ay, input logic [3:0] ax);
      logic [6:0] w;
      w = {ay, ax};
      for (int i = 6; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic pulse_stb(input logic state);
      DAT = state;
      tick(); tick();
      STB = 1'b1;
      tick(); tick(); tick();
      STB = 1'b0;
      tick(); tick();
   endtask

   task automatic send_cmd(input logic [2:0] ay, input logic [3:0] ax, input logic state);
      send_addr(ay, ax);
      pulse_stb(state);
   endtask

   initial begin
      DAT = 0; SK = 0; STB = 0; A = 16'hFFFF; M1 = 1; RD = 1; IORQ = 1; rst = 1;
      repeat (3) tick();
      rst = 0;
      tick();

      // Reset state
      A = 16'hFEFE; M1 = 1; RD = 0; IORQ = 0;
      #1;
      chk("rst_bus", {22'h0, D, enable, IORQGE}, {22'h0, 8'hFF, 1'b1, 1'b0});
      chk("rst_specials", {29'h0, MAGIC, PAUSE, RESET}, 32'h0);

      // Press AX=1 AY=2 with an explicit latency check
      A = 16'hFDFE;
      send_addr(3'd2, 4'd1);
      DAT = 1'b1;
      tick(); tick();
      STB = 1'b1;
      tick(); tick(); tick();
      chk("lat_edge_n2", {24'h0, D}, 32'hFF);
      tick();
      chk("lat_edge_n3", {24'h0, D}, 32'hFB);
      STB = 1'b0;
      tick(); tick(); tick();
      rd_chk("r1_other_row", 16'hFEFE, 8'hFF);
      send_cmd(3'd2, 4'd1, 1'b0);
      rd_chk("r1_released", 16'hFDFE, 8'hFF);

      // Table of bus reads with AX0/AY0 and AX7/AY4 pressed
      send_cmd(3'd0, 4'd0, 1'b1);
      send_cmd(3'd4, 4'd7, 1'b1);
      vec[0] = '{16'h7EFE, 1, 0, 0, 8'hEE, 1, 0, "rows0_7"};
      vec[1] = '{16'hFFFE, 1, 0, 0, 8'hFF, 1, 0, "no_row"};
      vec[2] = '{16'hFEFF, 1, 0, 0, 8'hFE, 0, 1, "odd_port"};
      vec[3] = '{16'hFEFE, 1, 0, 0, 8'hFE, 1, 0, "row0"};
      vec[4] = '{16'h7FFE, 1, 0, 0, 8'hEF, 1, 0, "row7"};
      vec[5] = '{16'h00FE, 1, 0, 0, 8'hEE, 1, 0, "all_rows"};
      vec[6] = '{16'hFEFE, 0, 0, 0, 8'hFE, 0, 1, "m1_cycle"};
      vec[7] = '{16'hFEFE, 1, 1, 0, 8'hFE, 0, 1, "no_rd"};
      vec[8] = '{16'hFEFE, 1, 0, 1, 8'hFE, 0, 0, "no_iorq"};
      vec[9] = '{16'hFDFE, 1, 0, 0, 8'hFF, 1, 0, "row1_idle"};
      for (int i = 0; i < 10; i++) begin
         A = vec[i].a; M1 = vec[i].m1; RD = vec[i].rd; IORQ = vec[i].iorq;
         #1;
         chk(vec[i].name, {22'h0, D, enable, IORQGE},
             {22'h0, vec[i].d, vec[i].en, vec[i].ge});
      end

      // Special keys
      send_cmd(3'd5, 4'd8, 1'b1);
      chk("magic_on", {29'h0, MAGIC, PAUSE, RESET}, 32'h4);
      send_cmd(3'd7, 4'd8, 1'b1);
      chk("pause_on", {29'h0, MAGIC, PAUSE, RESET}, 32'h6);
      send_cmd(3'd5, 4'd8, 1'b0);
      send_cmd(3'd7, 4'd8, 1'b0);
      chk("specials_off", {29'h0, MAGIC, PAUSE, RESET}, 32'h0);

      // Addresses that must be ignored
      send_cmd(3'd0, 4'd9, 1'b1);
      send_cmd(3'd6, 4'd0, 1'b1);
      send_cmd(3'd0, 4'd8, 1'b1);
      rd_chk("ignored_matrix", 16'h00FE, 8'hEE);
      chk("ignored_specials", {29'h0, MAGIC, PAUSE, RESET}, 32'h0);

      // Reset key held 10 cycles; RESET must stay high for exactly 100 cycles
      mon_en = 1'b1;
      send_addr(3'd6, 4'd8);
      pulse_stb(1'b1);
      tick(); tick(); tick();
      pulse_stb(1'b0);
      repeat (120) tick();
      mon_en = 1'b0;
      chk("reset_stretch_len", rst_hi, 100);
      chk("reset_released", {31'h0, RESET}, 32'h0);

      // Reset in the middle of a transfer, then a full command
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      rd_chk("midrst_cleared", 16'h00FE, 8'hFF);
      send_cmd(3'd3, 4'd2, 1'b1);
      rd_chk("midrst_cmd", 16'hFBFE, 8'hF7);

      // SK and STB rising together: decode uses the address before the shift
      send_addr(3'd2, 4'd1);
      DAT = 1'b1;
      tick(); tick();
      SK = 1'b1; STB = 1'b1;
      tick(); tick(); tick();
      SK = 1'b0; STB = 1'b0;
      tick(); tick(); tick();
      rd_chk("simul_old_addr", 16'hFDFE, 8'hFB);
      rd_chk("simul_new_addr", 16'hF7FE, 8'hFF);

`ifdef KBD_WATCHDOG_EN
      // Watchdog: release 64 cycles after the last applied STB, restart on a new STB
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      send_cmd(3'd0, 4'd0, 1'b1);
      send_cmd(3'd7, 4'd8, 1'b1);
      repeat (62) tick();
      chk("wdt_pause_before", {31'h0, PAUSE}, 32'h1);
      rd_chk("wdt_key_before", 16'hFEFE, 8'hFE);
      tick();
      chk("wdt_pause_after", {31'h0, PAUSE}, 32'h0);
      rd_chk("wdt_key_after", 16'hFEFE, 8'hFF);
      send_cmd(3'd0, 4'd0, 1'b1);
      repeat (62) tick();
      rd_chk("wdt_restart_before", 16'hFEFE, 8'hFE);
      tick();
      rd_chk("wdt_restart_after", 16'hFEFE, 8'hFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
